spi_frame_controller: RTL and testbench
=======================================

SPI_FRAME_CONTROLLER -- requirements
Module: spi_frame_controller

Interface
REQ-001 Parameter REG_COUNT, default 16, SHALL set the number of 8-bit frame registers (power of two, 2..64).
REQ-002 clock  in  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-004 io_InputBuffer  in  8  SHALL carry the last byte shifted in by SpiBuffer.
REQ-005 io_BufferChanged  in  1  SHALL carry SpiBuffer's byte-complete flag, already synchronous to clock.
REQ-006 io_ChipSelect  in  1  SHALL carry the SPI chip select, active-low, already synchronous to clock.
REQ-007 io_Avalon_address  in  7  SHALL carry the Avalon-MM word address.
REQ-008 io_Avalon_read / io_Avalon_write  in  1 each  SHALL carry the Avalon-MM read and write strobes.
REQ-009 io_Avalon_writedata  in  64  SHALL carry write data; only bits [7:0] are used for frame registers.
REQ-010 io_Avalon_readdata  out  64  SHALL carry read data, zero-extended.
REQ-011 io_FrameDone  out  1  SHALL carry a one-cycle pulse at the end of a committed frame.

Function
REQ-012 Byte strobe SHALL be the rising edge of io_BufferChanged (previous value registered) while io_ChipSelect=0.
REQ-013 FSM states SHALL be IDLE, ADDR, DATA and IGNORE.
REQ-014 IDLE->ADDR SHALL occur when io_ChipSelect=0; any state SHALL return to IDLE on the cycle io_ChipSelect=1 is sampled.
REQ-015 In ADDR, a byte strobe with byte < REG_COUNT SHALL load the write pointer and enter DATA; otherwise the FSM SHALL enter IGNORE.
REQ-016 In DATA, each byte strobe SHALL write io_InputBuffer to reg[pointer] on that cycle; the pointer SHALL then increment, wrapping REG_COUNT-1 -> 0.
REQ-017 IGNORE SHALL discard all bytes until io_ChipSelect=1.
REQ-018 io_FrameDone SHALL pulse on the cycle after leaving DATA with at least one data byte written; address-only and ignored frames SHALL NOT pulse.
REQ-019 Avalon write to an address < REG_COUNT SHALL update that register; a same-cycle SPI write to the same register SHALL win, and the Avalon write SHALL be dropped.
REQ-020 Avalon read SHALL have fixed latency 1, with io_Avalon_readdata valid the cycle after io_Avalon_read.
REQ-021 io_Avalon_readdata SHALL hold its value when io_Avalon_read=0.
REQ-022 Reads of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL be ignored.
REQ-023 Same-cycle read and write of one register SHALL return the pre-write value.

Reset
REQ-024 reset=0 SHALL clear all registers, the pointer, readdata, io_FrameDone and the registered io_BufferChanged, and force IDLE; this SHALL apply mid-frame, with the remainder of that frame ignored until io_ChipSelect=1.

Configuration
REQ-025 With SPI_FRAME_CTRL_STATUS_EN defined, the status register at address 7'h40 SHALL provide:
- [7:0] committed-frame count, wrapping 255->0
- [8] sticky collision flag (REQ-019)
- [9] sticky ignored-frame flag
An Avalon write to 7'h40 SHALL clear the status register.
REQ-026 Without SPI_FRAME_CTRL_STATUS_EN, 7'h40 SHALL be unmapped and no status logic SHALL exist.

Structure
REQ-027 Package spi_frame_pkg SHALL hold the FSM state enum, the REG_COUNT default and STATUS_ADDR=7'h40.
REQ-028 Sub-module spi_frame_regfile SHALL implement the register array: one SPI write port with priority, one Avalon write port, and one registered read port.

Verification
REQ-029 Frame CS low, then 0x03, 0xAA, 0xBB, then CS high -> reg3=0xAA, reg4=0xBB, one io_FrameDone pulse; a read of address 4 -> 0xBB one cycle later.
REQ-030 Frame 0x0F, 0x01, 0x02 -> reg15=0x01, reg0=0x02 (pointer wrap).
REQ-031 Frame 0x20, 0x55 -> no register change, no io_FrameDone; with STATUS_EN, status bit9=1.
REQ-032 SPI write of 0x11 and Avalon write of 0x22 to reg5 in the same cycle -> reg5=0x11; with STATUS_EN, status bit8=1.
REQ-033 Reset asserted after the address byte 0x02 while CS stays low, then more bytes -> all registers stay 0 and no io_FrameDone until a new CS-low frame.
REQ-034 With STATUS_EN, 256 committed frames -> count=0; an Avalon write to 7'h40 -> status reads 0.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame controller.
// The status register at STATUS_ADDR exists only when SPI_FRAME_CTRL_STATUS_EN is defined.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAddr   = 2'd1,
    StData   = 2'd2,
    StIgnore = 2'd3
  } frame_state_e;

  localparam int unsigned REG_COUNT_DEFAULT = 16;
  localparam logic [6:0]  STATUS_ADDR       = 7'h40;

endpackage

// File: rtl/spi_frame_regfile.sv
// Frame register array with a priority SPI write port, an Avalon write port and
// a registered read port whose output holds while no read is issued.
module spi_frame_regfile #(
  parameter int unsigned RegCount = 16,
  parameter int unsigned AddrW    = $clog2(RegCount)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             spi_we_i,
  input  logic [AddrW-1:0] spi_addr_i,
  input  logic [7:0]       spi_wdata_i,
  input  logic             av_we_i,
  input  logic [AddrW-1:0] av_addr_i,
  input  logic [7:0]       av_wdata_i,
  input  logic             rd_en_i,
  input  logic             rd_hit_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] regs_q [RegCount];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RegCount); i++) begin
        regs_q[i] <= 8'h00;
      end
      rd_data_q <= 8'h00;
    end else begin
      // Reads sample the array before this cycle's writes land.
      if (rd_en_i) begin
        rd_data_q <= rd_hit_i ? regs_q[rd_addr_i] : 8'h00;
      end
      for (int i = 0; i < int'(RegCount); i++) begin
        if (spi_we_i && (spi_addr_i == AddrW'(i))) begin
          regs_q[i] <= spi_wdata_i;
        end else if (av_we_i && (av_addr_i == AddrW'(i))) begin
          regs_q[i] <= av_wdata_i;
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spi_frame_controller.sv
// Decodes SPI byte frames (address byte, then data bytes) into a register file
// shared with an Avalon-MM slave. Optional status register: SPI_FRAME_CTRL_STATUS_EN.
module spi_frame_controller
  import spi_frame_pkg::*;
#(
  parameter int unsigned REG_COUNT = REG_COUNT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_InputBuffer,
  input  logic        io_BufferChanged,
  input  logic        io_ChipSelect,
  input  logic [6:0]  io_Avalon_address,
  input  logic        io_Avalon_read,
  input  logic        io_Avalon_write,
  input  logic [63:0] io_Avalon_writedata,
  output logic [63:0] io_Avalon_readdata,
  output logic        io_FrameDone
);

  localparam int unsigned AddrW = $clog2(REG_COUNT);

  logic [1:0]       state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic             wrote_q, wrote_d;
  logic             bc_q;
  logic             armed_q;
  logic             frame_done_q, frame_done_d;
  logic             strobe;
  logic             byte_in_range;
  logic             spi_we;
  logic             av_map;
  logic             av_we;
  logic [7:0]       rf_rd_data;
  logic             unused_wdata;

  assign unused_wdata  = ^io_Avalon_writedata[63:8];
  assign strobe        = io_BufferChanged & ~bc_q & ~io_ChipSelect;
  assign byte_in_range = {24'd0, io_InputBuffer} < REG_COUNT;
  assign av_map        = {25'd0, io_Avalon_address} < REG_COUNT;
  assign av_we         = io_Avalon_write & av_map;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wrote_d = wrote_q;
    spi_we  = 1'b0;
    if (io_ChipSelect) begin
      state_d = StIdle;
      wrote_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // After a reset, wait for a clean chip-select deassertion first.
          if (armed_q) begin
            state_d = StAddr;
            wrote_d = 1'b0;
          end
        end
        StAddr: begin
          if (strobe) begin
            if (byte_in_range) begin
              ptr_d   = io_InputBuffer[AddrW-1:0];
              state_d = StData;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StData: begin
          if (strobe) begin
            spi_we  = 1'b1;
            ptr_d   = ptr_q + AddrW'(1);
            wrote_d = 1'b1;
          end
        end
        StIgnore: state_d = StIgnore;
        default:  state_d = StIdle;
      endcase
    end
  end

  assign frame_done_d = io_ChipSelect & (state_q == StData) & wrote_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      wrote_q      <= 1'b0;
      bc_q         <= 1'b0;
      armed_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wrote_q      <= wrote_d;
      bc_q         <= io_BufferChanged;
      armed_q      <= armed_q | io_ChipSelect;
      frame_done_q <= frame_done_d;
    end
  end

  assign io_FrameDone = frame_done_q;

  spi_frame_regfile #(
    .RegCount (REG_COUNT)
  ) u_regfile (
    .clk_i       (clock),
    .rst_ni      (reset),
    .spi_we_i    (spi_we),
    .spi_addr_i  (ptr_q),
    .spi_wdata_i (io_InputBuffer),
    .av_we_i     (av_we),
    .av_addr_i   (io_Avalon_address[AddrW-1:0]),
    .av_wdata_i  (io_Avalon_writedata[7:0]),
    .rd_en_i     (io_Avalon_read),
    .rd_hit_i    (av_map),
    .rd_addr_i   (io_Avalon_address[AddrW-1:0]),
    .rd_data_o   (rf_rd_data)
  );

`ifdef SPI_FRAME_CTRL_STATUS_EN
  logic [7:0] cnt_q;
  logic       coll_q;
  logic       ign_q;
  logic       sel_status_q;
  logic [9:0] status_rd_q;
  logic       status_hit;
  logic       status_clr;
  logic       collision;
  logic       ignore_evt;

  assign status_hit = io_Avalon_address == STATUS_ADDR;
  assign status_clr = io_Avalon_write & status_hit;
  assign collision  = spi_we & av_we & (ptr_q == io_Avalon_address[AddrW-1:0]);
  assign ignore_evt = ~io_ChipSelect & (state_q == StAddr) & strobe & ~byte_in_range;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q        <= 8'h00;
      coll_q       <= 1'b0;
      ign_q        <= 1'b0;
      sel_status_q <= 1'b0;
      status_rd_q  <= 10'h000;
    end else begin
      // Events in the clearing cycle still register after the clear.
      cnt_q  <= (status_clr ? 8'h00 : cnt_q) + {7'd0, frame_done_d};
      coll_q <= (~status_clr & coll_q) | collision;
      ign_q  <= (~status_clr & ign_q) | ignore_evt;
      if (io_Avalon_read) begin
        sel_status_q <= status_hit;
        status_rd_q  <= {ign_q, coll_q, cnt_q};
      end
    end
  end

  assign io_Avalon_readdata = sel_status_q ? {54'd0, status_rd_q} : {56'd0, rf_rd_data};
`else
  assign io_Avalon_readdata = {56'd0, rf_rd_data};
`endif

endmodule

// File: tb/tb_spi_frame_controller.sv
// Directed self-checking bench for spi_frame_controller (default REG_COUNT=16).
module tb_spi_frame_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  ib;
  logic        bc;
  logic        cs;
  logic [6:0]  addr;
  logic        rd;
  logic        wr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        fd;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  spi_frame_controller #(
    .REG_COUNT (16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .io_InputBuffer      (ib),
    .io_BufferChanged    (bc),
    .io_ChipSelect       (cs),
    .io_Avalon_address   (addr),
    .io_Avalon_read      (rd),
    .io_Avalon_write     (wr),
    .io_Avalon_writedata (wdata),
    .io_Avalon_readdata  (rdata),
    .io_FrameDone        (fd)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (fd === 1'b1) fd_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ib = b;
    bc = 1'b1;
    tick();
    bc = 1'b0;
    tick();
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick();
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick();
    tick();
  endtask

  task automatic av_read(input logic [6:0] a, output logic [63:0] d);
    addr = a;
    rd   = 1'b1;
    tick();
    rd   = 1'b0;
    d    = rdata;
  endtask

  task automatic av_write(input logic [6:0] a, input logic [7:0] v);
    addr  = a;
    wdata = {56'hFFFF_FFFF_FFFF_FF, v};
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset = 1'b0;
    cs = 1'b1; bc = 1'b0; ib = 8'h00; addr = 7'h00; rd = 1'b0; wr = 1'b0; wdata = '0;
    tick(); tick();
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL reset_readdata got %h want 0", rdata);
    end
    checks++;
    if (fd !== 1'b0) begin
      errors++; $display("FAIL reset_framedone got %b want 0", fd);
    end
    reset = 1'b1;
    tick();
    av_read(7'd3, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL reset_reg3 got %h want 0", d);
    end
  endtask

  task automatic test_basic_frame();
    logic [63:0] d;
    int f0;
    f0 = fd_cnt;
    cs_low();
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
    cs_high();
    checks++;
    if (fd_cnt - f0 !== 1) begin
      errors++; $display("FAIL basic_framedone got %0d pulses want 1", fd_cnt - f0);
    end
    av_read(7'd4, d);
    checks++;
    if (d !== 64'hBB) begin
      errors++; $display("FAIL basic_reg4 got %h want bb", d);
    end
    tick();
    checks++;
    if (rdata !== 64'hBB) begin
      errors++; $display("FAIL read_hold got %h want bb", rdata);
    end
    av_read(7'd3, d);
    checks++;
    if (d !== 64'hAA) begin
      errors++; $display("FAIL basic_reg3 got %h want aa", d);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] d;
    cs_low();
    send_byte(8'h0F); send_byte(8'h01); send_byte(8'h02);
    cs_high();
    av_read(7'd15, d);
    checks++;
    if (d !== 64'h01) begin
      errors++; $display("FAIL wrap_reg15 got %h want 01", d);
    end
    av_read(7'd0, d);
    checks++;
    if (d !== 64'h02) begin
      errors++; $display("FAIL wrap_reg0 got %h want 02", d);
    end
  endtask

  task automatic test_ignore();
    logic [63:0] d;
    int f0;
    f0 = fd_cnt;
    cs_low();
    send_byte(8'h20); send_byte(8'h55);
    cs_high();
    cs_low();
    send_byte(8'h06);
    cs_high();
    checks++;
    if (fd_cnt !== f0) begin
      errors++; $display("FAIL ignore_framedone got %0d pulses want 0", fd_cnt - f0);
    end
    av_read(7'd0, d);
    checks++;
    if (d !== 64'h02) begin
      errors++; $display("FAIL ignore_reg0 got %h want 02", d);
    end
    av_read(7'd6, d);
    checks++;
    if (d !== 64'h00) begin
      errors++; $display("FAIL addr_only_reg6 got %h want 00", d);
    end
`ifdef SPI_FRAME_CTRL_STATUS_EN
    av_read(7'h40, d);
    checks++;
    if (d[9] !== 1'b1) begin
      errors++; $display("FAIL status_ignored got %b want 1", d[9]);
    end
`endif
  endtask

  task automatic test_avalon();
    logic [63:0] d;
    av_write(7'd7, 8'h77);
    av_read(7'd7, d);
    checks++;
    if (d !== 64'h77) begin
      errors++; $display("FAIL av_write_reg7 got %h want 77", d);
    end
    av_write(7'h30, 8'h5A);
    av_read(7'h30, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL unmapped_read got %h want 0", d);
    end
`ifndef SPI_FRAME_CTRL_STATUS_EN
    av_read(7'h40, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL status_unmapped got %h want 0", d);
    end
`endif
    // Same-cycle read and write return the old contents.
    addr = 7'd7; wdata = 64'h99; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (rdata !== 64'h77) begin
      errors++; $display("FAIL rw_same_cycle got %h want 77", rdata);
    end
    av_read(7'd7, d);
    checks++;
    if (d !== 64'h99) begin
      errors++; $display("FAIL rw_after got %h want 99", d);
    end
  endtask

  task automatic test_collision();
    logic [63:0] d;
    cs_low();
    send_byte(8'h05);
    ib = 8'h11; bc = 1'b1;
    addr = 7'd5; wdata = 64'h22; wr = 1'b1;
    tick();
    bc = 1'b0; wr = 1'b0;
    tick();
    cs_high();
    av_read(7'd5, d);
    checks++;
    if (d !== 64'h11) begin
      errors++; $display("FAIL collision_reg5 got %h want 11", d);
    end
`ifdef SPI_FRAME_CTRL_STATUS_EN
    av_read(7'h40, d);
    checks++;
    if (d[8] !== 1'b1) begin
      errors++; $display("FAIL status_collision got %b want 1", d[8]);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [63:0] d;
    int f0;
    f0 = fd_cnt;
    cs_low();
    send_byte(8'h02);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    send_byte(8'h33); send_byte(8'h44);
    cs_high();
    checks++;
    if (fd_cnt !== f0) begin
      errors++; $display("FAIL midreset_framedone got %0d pulses want 0", fd_cnt - f0);
    end
    av_read(7'd2, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL midreset_reg2 got %h want 0", d);
    end
    av_read(7'd5, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL midreset_reg5 got %h want 0", d);
    end
    f0 = fd_cnt;
    cs_low();
    send_byte(8'h01); send_byte(8'h66);
    cs_high();
    av_read(7'd1, d);
    checks++;
    if (d !== 64'h66 || fd_cnt - f0 !== 1) begin
      errors++; $display("FAIL after_reset_frame got %h/%0d want 66/1", d, fd_cnt - f0);
    end
  endtask

`ifdef SPI_FRAME_CTRL_STATUS_EN
  task automatic test_status_count();
    logic [63:0] d;
    av_write(7'h40, 8'h00);
    av_read(7'h40, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL status_clear got %h want 0", d);
    end
    for (int i = 0; i < 255; i++) begin
      cs_low(); send_byte(8'h08); send_byte(i[7:0]); cs_high();
    end
    av_read(7'h40, d);
    checks++;
    if (d !== 64'hFF) begin
      errors++; $display("FAIL status_count255 got %h want ff", d);
    end
    cs_low(); send_byte(8'h08); send_byte(8'h01); cs_high();
    av_read(7'h40, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL status_wrap got %h want 0", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_wrap();
    test_ignore();
    test_avalon();
    test_collision();
    test_reset_midframe();
`ifdef SPI_FRAME_CTRL_STATUS_EN
    test_status_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
